// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Brief    : Register-read stage with writeback forwarding, scoreboard
//             hazard stalls and a one-entry valid/ready output register.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_wen,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_rv1,
    input  logic [XLEN-1:0] rf_rv2,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd,
    output logic            out_wen,
    output logic [NREG-1:0] busy
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_X0 = '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [AW-1:0]     r_rd;
    logic              r_wen;
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;

    logic              w_fwd1;
    logic              w_fwd2;
    logic              w_fwd_rd;
    logic              w_pend1;
    logic              w_pend2;
    logic              w_pend_rd;
    logic              w_hazard;
    logic              w_accept;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;

    assign rf_rs1 = in_rs1;
    assign rf_rs2 = in_rs2;

    // A writeback this cycle resolves the pending producer of its register.
    assign w_fwd1    = wb_valid && (wb_rd == in_rs1) && (in_rs1 != c_X0);
    assign w_fwd2    = wb_valid && (wb_rd == in_rs2) && (in_rs2 != c_X0);
    assign w_fwd_rd  = wb_valid && (wb_rd == in_rd)  && (in_rd  != c_X0);

    assign w_pend1   = (in_rs1 != c_X0) && r_busy[in_rs1] && !w_fwd1;
    assign w_pend2   = (in_rs2 != c_X0) && r_busy[in_rs2] && !w_fwd2;
    assign w_pend_rd = (in_rd  != c_X0) && r_busy[in_rd]  && !w_fwd_rd;

    assign w_hazard  = w_pend1 || w_pend2 || (in_wen && w_pend_rd);
    assign in_ready  = ((r_state == ST_EMPTY) || out_ready) && !w_hazard;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        if (in_rs1 == c_X0) begin
            w_op1 = '0;
        end else if (w_fwd1) begin
            w_op1 = wb_data;
        end else begin
            w_op1 = rf_rv1;
        end
        if (in_rs2 == c_X0) begin
            w_op2 = '0;
        end else if (w_fwd2) begin
            w_op2 = wb_data;
        end else begin
            w_op2 = rf_rv2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Clear before set so a same-cycle new producer keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid && (wb_rd != c_X0)) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_accept && in_wen && (in_rd != c_X0)) begin
            w_busy_nxt[in_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_op1   <= '0;
            r_op2   <= '0;
            r_rd    <= '0;
            r_wen   <= 1'b0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            if (w_accept) begin
                r_op1 <= w_op1;
                r_op2 <= w_op2;
                r_rd  <= in_rd;
                r_wen <= in_wen;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_op1   = r_op1;
    assign out_op2   = r_op2;
    assign out_rd    = r_rd;
    assign out_wen   = r_wen;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch
//  Brief    : Directed self-checking bench for operand_fetch with a small
//             register-file model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic [AW-1:0]   in_rd;
    logic            in_wen;
    logic [AW-1:0]   rf_rs1;
    logic [AW-1:0]   rf_rs2;
    logic [XLEN-1:0] rf_rv1;
    logic [XLEN-1:0] rf_rv2;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [AW-1:0]   out_rd;
    logic            out_wen;
    logic [NREG-1:0] busy;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] r_rf [0:NREG-1];

    operand_fetch #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .rf_rs1    (rf_rs1),
        .rf_rs2    (rf_rs2),
        .rf_rv1    (rf_rv1),
        .rf_rv2    (rf_rv2),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_wen   (out_wen),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: x3=5, x4=7 after reset; writeback updates it.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= (i == 3) ? 32'd5 : (i == 4) ? 32'd7 : 32'd0;
            end
        end else if (wb_valid && (wb_rd != '0)) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    assign rf_rv1 = r_rf[rf_rs1];
    assign rf_rv2 = r_rf[rf_rs2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [AW-1:0] d, input logic w);
        in_valid = v;
        in_rs1   = s1;
        in_rs2   = s2;
        in_rd    = d;
        in_wen   = w;
    endtask

    task automatic wb(input logic v, input logic [AW-1:0] d, input logic [XLEN-1:0] data);
        wb_valid = v;
        wb_rd    = d;
        wb_data  = data;
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 32'd0);
        cyc();
        cyc();
        reset = 1'b1;

        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {32'd0, busy}, 64'd0);
        check("rst_op1", {32'd0, out_op1}, 64'd0);
        check("rst_rd_wen", {58'd0, out_rd, out_wen}, 64'd0);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Plain read from the register file
        issue(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
        #1;
        check("rd_in_ready", {63'd0, in_ready}, 64'd1);
        check("rf_addr", {54'd0, rf_rs1, rf_rs2}, {54'd0, 5'd3, 5'd4});
        cyc();
        check("rd_valid", {63'd0, out_valid}, 64'd1);
        check("rd_ops", {out_op1, out_op2}, {32'd5, 32'd7});
        check("rd_rd_wen", {58'd0, out_rd, out_wen}, {58'd0, 5'd5, 1'b1});
        check("rd_busy", {32'd0, busy}, 64'h20);

        // RAW stall on x5, resolved by same-cycle writeback forwarding
        issue(1'b1, 5'd5, 5'd4, 5'd7, 1'b1);
        #1;
        check("raw_stall", {63'd0, in_ready}, 64'd0);
        cyc();
        check("raw_drained", {63'd0, out_valid}, 64'd0);
        check("raw_busy_kept", {32'd0, busy}, 64'h20);
        wb(1'b1, 5'd5, 32'h2A);
        #1;
        check("raw_fwd_ready", {63'd0, in_ready}, 64'd1);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        check("fwd_valid", {63'd0, out_valid}, 64'd1);
        check("fwd_ops", {out_op1, out_op2}, {32'h2A, 32'd7});
        check("fwd_busy", {32'd0, busy}, 64'h80);

        // Backpressure: outputs hold, nothing accepted
        out_ready = 1'b0;
        issue(1'b1, 5'd3, 5'd4, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            cyc();
            check("bp_hold", {out_op1, out_op2}, {32'h2A, 32'd7});
            check("bp_hold_ctl", {57'd0, out_valid, out_rd, out_wen}, {57'd0, 1'b1, 5'd7, 1'b1});
            check("bp_busy", {32'd0, busy}, 64'h80);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", {63'd0, in_ready}, 64'd1);
        cyc();
        check("bp_new_ops", {out_op1, out_op2}, {32'd5, 32'd7});
        check("bp_new_busy", {32'd0, busy}, 64'h280);

        // x0 sources and destination, writeback to x0 is ignored
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        wb(1'b1, 5'd0, 32'hDEAD);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        check("x0_ops", {out_op1, out_op2}, 64'd0);
        check("x0_rd", {58'd0, out_rd, out_wen}, {58'd0, 5'd0, 1'b1});
        check("x0_busy", {32'd0, busy}, 64'h280);

        // Set busy[6], then same-cycle writeback and new producer of x6
        issue(1'b1, 5'd3, 5'd4, 5'd6, 1'b1);
        cyc();
        check("b6_set", {32'd0, busy}, 64'h2C0);
        issue(1'b1, 5'd6, 5'd4, 5'd6, 1'b1);
        wb(1'b1, 5'd6, 32'h55);
        #1;
        check("b6_ready", {63'd0, in_ready}, 64'd1);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        check("b6_set_wins", {32'd0, busy}, 64'h2C0);
        check("b6_fwd_op1", {32'd0, out_op1}, {32'd0, 32'h55});

        // WAW on busy x9 stalls; the same rd without write enable does not
        issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        #1;
        check("waw_stall", {63'd0, in_ready}, 64'd0);
        issue(1'b1, 5'd0, 5'd12, 5'd9, 1'b0);
        wb(1'b1, 5'd12, 32'h77);
        #1;
        check("nowen_ready", {63'd0, in_ready}, 64'd1);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        check("nb_wb_fwd", {out_op1, out_op2}, {32'd0, 32'h77});
        check("nb_wb_busy", {32'd0, busy}, 64'h2C0);
        check("nowen_wen", {63'd0, out_wen}, 64'd0);

        // Mid-stream reset with a held output and pending busy bits
        out_ready = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        check("mrst_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_busy", {32'd0, busy}, 64'd0);
        check("mrst_ops", {out_op1, out_op2}, 64'd0);
        #1;
        check("mrst_ready", {63'd0, in_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
